// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, WIDTH iterations plus one sign-fix cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_div_q, zero_div_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & op_a[WIDTH-1];
        b_neg     = is_signed & op_b[WIDTH-1];
        a_abs     = a_neg ? -op_a : op_a;
        b_abs     = b_neg ? -op_b : op_b;

        // Multiply: accumulator holds {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
        div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        b_d        = b_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        zero_div_d = zero_div_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                // Writes are held off in the done cycle so the fresh result survives.
                if (!done_q) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
                if (start && !flush) begin
                    state_d    = S_RUN;
                    count_d    = CW'(WIDTH);
                    acc_d      = {{WIDTH{1'b0}}, a_abs};
                    b_d        = b_abs;
                    a_raw_d    = op_a;
                    is_div_d   = op[1];
                    neg_d      = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    zero_div_d = op[1] & (op_b == '0);
                    dbz_d      = 1'b0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = is_div_q ? div_next : mul_next;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (zero_div_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            zero_div_q <= zero_div_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
